serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_ctrl_if.sv | 37 +++
 rtl/FullAdder.sv | 13 +
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional feature macro: SERIAL_ADD_SUBTRACT_EN (adds a subtract request bit).
package serial_add_pkg;

  localparam int SERIAL_ADD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width for an n-bit operand; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle of the bit-serial adder: start/done handshake, operands and result.
// Optional feature macro: SERIAL_ADD_SUBTRACT_EN adds the sub request bit.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int N = SERIAL_ADD_W
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUBTRACT_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_SUBTRACT_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_SUBTRACT_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );

endinterface

// File: rtl/FullAdder.sv
// The team's 1-bit full-adder cell, used as the shared serial datapath.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one FullAdder cell sequenced LSB first over N cycles.
// Optional feature macro: SERIAL_ADD_SUBTRACT_EN (sub=1 computes a - b, cout=1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N = SERIAL_ADD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_ctrl_if.slave    bus
);

  localparam int              CNT_W    = cnt_w(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     a_sr, b_sr, s_sr;
  logic [N-1:0]     sum_q;
  logic             carry_q, cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fa_s, fa_co;
  logic             accept, last_bit;
  logic [N-1:0]     b_load;
  logic             cin_load;

  // Operand B and carry as loaded: subtraction is a + ~b + 1 through the same cell.
  always_comb begin
    b_load   = bus.b;
    cin_load = bus.cin;
`ifdef SERIAL_ADD_SUBTRACT_EN
    if (bus.sub) begin
      b_load   = ~bus.b;
      cin_load = 1'b1;
    end
`endif
  end

  FullAdder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next-state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shift registers are plain flops rather than a memory array, so they are reset with the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_sr    <= bus.a;
        b_sr    <= b_load;
        carry_q <= cin_load;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        s_sr    <= {fa_s, s_sr[N-1:1]};
        a_sr    <= {1'b0, a_sr[N-1:1]};
        b_sr    <= {1'b0, b_sr[N-1:1]};
        carry_q <= fa_co;
        if (!last_bit) cnt_q <= cnt_q + 1'b1;
      end
      // The result register includes the bit produced on this final edge.
      if (last_bit) begin
        sum_q  <= {fa_s, s_sr[N-1:1]};
        cout_q <= fa_co;
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random operands against an arithmetic model.
// Optional feature macro: SERIAL_ADD_SUBTRACT_EN enables the subtract cases.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int N   = SERIAL_ADD_W;
  localparam int TMO = 4 * N;

  logic clk = 1'b0;
  logic rst_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] prev_sum;
  logic         prev_cout;
  bit           after_done;

  serial_add_ctrl_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cout, sum} from plain (N+1)-bit arithmetic.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic cin, input logic sub);
    logic [N:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    else     r = {1'b0, a} + {1'b0, b}  + {{N{1'b0}}, cin};
    return r;
  endfunction

  task automatic drive_req(input logic st, input logic [N-1:0] a_v, input logic [N-1:0] b_v,
                           input logic cin_v, input logic sub_v);
    bus.start = st;
    bus.a     = a_v;
    bus.b     = b_v;
    bus.cin   = cin_v;
`ifdef SERIAL_ADD_SUBTRACT_EN
    bus.sub   = sub_v;
`else
    if (sub_v) $display("note: sub requested without subtract support");
`endif
  endtask

  // One operation; the start is raised in the first cycle after the previous DONE.
  task automatic run_op(input string tag, input logic [N-1:0] a_v, input logic [N-1:0] b_v,
                        input logic cin_v, input logic sub_v, input bit spam);
    logic [N:0] exp_r;
    int         busy_cnt, done_at;
    logic       held_ok;
    exp_r = model(a_v, b_v, cin_v, sub_v);
    @(negedge clk);
    if (after_done) check({tag, "/idle_after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
    drive_req(1'b1, a_v, b_v, cin_v, sub_v);
    @(negedge clk);
    busy_cnt = 0;
    done_at  = -1;
    held_ok  = 1'b1;
    for (int i = 0; i < TMO && done_at < 0; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_at = i;
      else if (bus.sum !== prev_sum || bus.cout !== prev_cout) held_ok = 1'b0;
      if (spam) drive_req(1'b1, '1, N'($urandom), 1'($urandom), 1'b0);
      else      drive_req(1'b0, N'($urandom), N'($urandom), 1'($urandom), 1'b0);
      if (done_at < 0) @(negedge clk);
    end
    check({tag, "/done_at"}, 32'(done_at), 32'(N));
    check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(N + 1));
    check({tag, "/result"}, 32'({bus.cout, bus.sum}), 32'(exp_r));
    check({tag, "/prev_held"}, {31'd0, held_ok}, 32'd1);
    prev_sum   = exp_r[N-1:0];
    prev_cout  = exp_r[N];
    after_done = 1'b1;
  endtask

  initial begin
    int   done_seen;
    logic [N-1:0] ra, rb;
    logic rc, rs;

    rst_n      = 1'b1;
    prev_sum   = '0;
    prev_cout  = 1'b0;
    after_done = 1'b0;
    drive_req(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("reset/outputs", 32'({bus.busy, bus.done, bus.cout, bus.sum}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("zero",       8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("ff_plus_1",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("a5_5a_c1",   8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    run_op("restart_ign", 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1);
    run_op("b2b_1",      8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("b2b_2",      8'h80, 8'h80, 1'b0, 1'b0, 1'b0);

    // Reset in the fourth RUN cycle: outputs clear at once and no done follows.
    @(negedge clk);
    drive_req(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrun_reset/outputs", 32'({bus.busy, bus.done, bus.cout, bus.sum}), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("midrun_reset/no_done", 32'(done_seen), 32'd0);
    prev_sum   = '0;
    prev_cout  = 1'b0;
    after_done = 1'b0;

`ifdef SERIAL_ADD_SUBTRACT_EN
    run_op("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    run_op("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1, 1'b0);
`endif

    for (int k = 0; k < 24; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUBTRACT_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rand%0d", k), ra, rb, rc, rs, bit'(k % 5 == 0));
    end

    @(negedge clk);
    check("final/idle", {30'd0, bus.busy, bus.done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
